// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: locks to HS/VS timing and reports active-area coordinates.
// Define VGA_SYNC_DECODER_ERRCNT_EN to build the saturating lock-loss counter on err_cnt.
module vga_sync_decoder #(
  parameter int H_SYNC  = 120,
  parameter int H_BP    = 64,
  parameter int H_ACT   = 800,
  parameter int H_TOTAL = 1040,
  parameter int V_SYNC  = 6,
  parameter int V_BP    = 23,
  parameter int V_ACT   = 600,
  parameter int V_TOTAL = 666
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_STOP  = 11'(H_SYNC + H_BP + H_ACT);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_MISS  = 11'(H_TOTAL);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_STOP  = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {SEARCH, HTRACK, VTRACK, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  hs_sync, vs_sync;  // [0],[1] synchronizer, [2] history
  logic        hs_fall, vs_fall;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        line_err, frame_ok, in_window;
  logic [10:0] pix_x_next;
  logic [9:0]  pix_y_next;
  logic        pix_valid_next, locked_next, fs_flag_next, fs_flag_reg;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      hs_sync <= '1;
      vs_sync <= '1;
    end else begin
      hs_sync <= {hs_sync[1:0], vga_hs};
      vs_sync <= {vs_sync[1:0], vga_vs};
    end
  end

  assign hs_fall = hs_sync[2] & ~hs_sync[1];
  assign vs_fall = vs_sync[2] & ~vs_sync[1];

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != '1)
        h_cnt <= h_cnt + 11'd1;
      if (vs_fall)
        v_cnt <= '0;
      else if (hs_fall && v_cnt != '1)
        v_cnt <= v_cnt + 10'd1;
    end
  end

  // A line is bad if it ends at the wrong length or runs past H_TOTAL without a pulse.
  assign line_err = hs_fall ? (h_cnt != H_LAST) : (h_cnt == H_MISS);
  assign frame_ok = (v_cnt == V_LAST);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)
      state_reg <= SEARCH;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEARCH: if (hs_fall) state_next = HTRACK;
      HTRACK: if (vs_fall && !line_err) state_next = VTRACK;
      VTRACK: begin
        if (line_err)
          state_next = SEARCH;
        else if (vs_fall && frame_ok)
          state_next = LOCKED;
      end
      LOCKED: if (line_err || (vs_fall && !frame_ok)) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    in_window      = (h_cnt >= H_START) && (h_cnt < H_STOP) &&
                     (v_cnt >= V_START) && (v_cnt < V_STOP);
    pix_valid_next = (state_reg == LOCKED) && in_window;
    pix_x_next     = '0;
    pix_y_next     = '0;
    if (pix_valid_next) begin
      pix_x_next = h_cnt - H_START;
      pix_y_next = v_cnt - V_START;
    end
    locked_next  = (state_reg == LOCKED);
    fs_flag_next = vs_fall && (state_reg == LOCKED) && (state_next == LOCKED);
  end

  // frame_start is staged through fs_flag_reg so it lines up with the other outputs.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      locked      <= 1'b0;
      fs_flag_reg <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= pix_x_next;
      pix_y       <= pix_y_next;
      pix_valid   <= pix_valid_next;
      locked      <= locked_next;
      fs_flag_reg <= fs_flag_next;
      frame_start <= fs_flag_reg;
    end
  end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] err_reg;

  // locked still high while the FSM has already left LOCKED marks exactly one loss.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)
      err_reg <= '0;
    else if (locked && state_reg != LOCKED && err_reg != 8'hFF)
      err_reg <= err_reg + 8'd1;
  end

  assign err_cnt = err_reg;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced 8x6-line format so that locks and losses fit a short run.
module tb_vga_sync_decoder;

  localparam int HS  = 2;
  localparam int HBP = 1;
  localparam int HA  = 4;
  localparam int HT  = 8;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VA  = 3;
  localparam int VT  = 6;

  localparam int P_SEARCH = 0;
  localparam int P_HTRACK = 1;
  localparam int P_VTRACK = 2;
  localparam int P_LOCKED = 3;

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_50m = 1'b0;
  logic        rst     = 1'b1;
  logic        vga_hs  = 1'b1;
  logic        vga_vs  = 1'b1;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid, frame_start, locked;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACT(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACT(VA), .V_TOTAL(VT)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  // Reference model: positions from timestamps of the delayed sync falls, lock from frame rules.
  int          m_edge = 0, m_last_hs = 0, m_nhs = 0, m_phase = P_SEARCH, m_err = 0;
  bit          m_prev_hs = 1'b1, m_prev_vs = 1'b1;
  bit   [1:0]  m_dhs = '0, m_dvs = '0;
  logic [31:0] exp_out = '0, pend_out = '0;

  task automatic model_step();
    int hb, vb, h, v, px, py, old;
    bit act_hs, act_vs, bad, pv, fs;
    if (rst) begin
      m_edge = 0; m_last_hs = 0; m_nhs = 0; m_phase = P_SEARCH; m_err = 0;
      m_prev_hs = 1'b1; m_prev_vs = 1'b1; m_dhs = '0; m_dvs = '0;
      exp_out = '0; pend_out = '0;
      return;
    end
    m_edge++;
    exp_out = pend_out;
    act_hs = m_dhs[1];
    act_vs = m_dvs[1];
    m_dhs = {m_dhs[0], m_prev_hs & ~vga_hs};
    m_dvs = {m_dvs[0], m_prev_vs & ~vga_vs};
    m_prev_hs = vga_hs;
    m_prev_vs = vga_vs;
    hb = m_edge - 1 - m_last_hs;
    if (hb > 2047) hb = 2047;
    vb = (m_nhs > 1023) ? 1023 : m_nhs;
    bad = act_hs ? (hb + 1 != HT) : (hb == HT);
    old = m_phase;
    case (m_phase)
      P_SEARCH: if (act_hs) m_phase = P_HTRACK;
      P_HTRACK: if (act_vs && !bad) m_phase = P_VTRACK;
      P_VTRACK: begin
        if (bad) m_phase = P_SEARCH;
        else if (act_vs && vb + 1 == VT) m_phase = P_LOCKED;
      end
      default: if (bad || (act_vs && vb + 1 != VT)) m_phase = P_SEARCH;
    endcase
    if (act_hs) m_last_hs = m_edge;
    if (act_vs) m_nhs = 0;
    else if (act_hs) m_nhs++;
    h = m_edge - m_last_hs;
    if (h > 2047) h = 2047;
    v = (m_nhs > 1023) ? 1023 : m_nhs;
    pv = (m_phase == P_LOCKED) && h >= HS + HBP && h < HS + HBP + HA &&
         v >= VS + VBP && v < VS + VBP + VA;
    px = pv ? h - (HS + HBP) : 0;
    py = pv ? v - (VS + VBP) : 0;
    fs = act_vs && old == P_LOCKED && m_phase == P_LOCKED;
    if (ERR_EN && old == P_LOCKED && m_phase != P_LOCKED && m_err < 255) m_err++;
    pend_out = {11'(px), 10'(py), pv, fs, (m_phase == P_LOCKED), 8'(m_err)};
  endtask

  initial forever begin
    @(posedge clk_50m or posedge rst);
    model_step();
  end

  initial forever begin
    logic [31:0] got;
    @(negedge clk_50m);
    if (!rst) begin
      got = {pix_x, pix_y, pix_valid, frame_start, locked, err_cnt};
      checks++;
      if (got !== exp_out) begin
        errors++;
        $display("FAIL outputs cycle %0d: got x=%0d y=%0d v=%0b fs=%0b lk=%0b err=%0d, want x=%0d y=%0d v=%0b fs=%0b lk=%0b err=%0d",
                 cyc, got[31:21], got[20:11], got[10], got[9], got[8], got[7:0],
                 exp_out[31:21], exp_out[20:11], exp_out[10], exp_out[9], exp_out[8], exp_out[7:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("check %s: got %0d, want %0d", name, got, want);
    end
  endtask

  int lock_t = -1000, pix_t = -1000, fs_t = -1000;
  bit arm_lock = 1'b0, arm_pix = 1'b0, arm_fs = 1'b0;

  // One clock of stimulus; outputs seen here reflect edge number cyc.
  task automatic tick(input logic hs, input logic vs);
    @(posedge clk_50m);
    #1;
    if (cyc == lock_t + 2) check("lock_before", {31'd0, locked}, 32'd0);
    if (cyc == lock_t + 3) check("lock_rise", {31'd0, locked}, 32'd1);
    if (cyc == fs_t + 2)   check("fs_before", {31'd0, frame_start}, 32'd0);
    if (cyc == fs_t + 3)   check("fs_pulse", {31'd0, frame_start}, 32'd1);
    if (cyc == fs_t + 4)   check("fs_after", {31'd0, frame_start}, 32'd0);
    if (cyc == pix_t + 6)  check("pix_first", {pix_valid, pix_x, pix_y}, {1'b1, 11'd0, 10'd1});
    if (cyc == pix_t + 9)  check("pix_last", {pix_valid, pix_x, pix_y}, {1'b1, 11'd3, 10'd1});
    if (cyc == pix_t + 10) check("pix_after", {31'd0, pix_valid}, 32'd0);
    if (vga_hs && !hs) begin
      if (arm_lock) begin lock_t = cyc + 1; arm_lock = 1'b0; end
      if (arm_pix)  begin pix_t  = cyc + 1; arm_pix  = 1'b0; end
      if (arm_fs)   begin fs_t   = cyc + 1; arm_fs   = 1'b0; end
    end
    vga_hs = hs;
    vga_vs = vs;
  endtask

  task automatic send_line(input int len, input bit vs_low, input bit pulse);
    for (int i = 0; i < len; i++)
      tick((pulse && i < HS) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1);
  endtask

  task automatic send_frame(input int short_line, input int miss_line, input bit arm_px);
    for (int l = 0; l < VT; l++) begin
      if (arm_px && l == 3) arm_pix = 1'b1;
      send_line((l == short_line) ? HT - 1 : HT, l < VS, l != miss_line);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_50m);
    #2;
    check("reset_outputs", {pix_x, pix_y, pix_valid, frame_start, locked, err_cnt}, 32'd0);
    rst = 1'b0;
    repeat (5) tick(1'b1, 1'b1);

    $display("phase nominal lock");
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    arm_lock = 1'b1;
    send_frame(-1, -1, 1'b0);
    check("locked_nominal", {31'd0, locked}, 32'd1);
    check("err_nominal", {24'd0, err_cnt}, 32'd0);

    $display("phase pixel mapping");
    arm_fs = 1'b1;
    send_frame(-1, -1, 1'b1);

    $display("phase missing hs pulse");
    send_frame(-1, 2, 1'b0);
    check("miss_unlocked", {31'd0, locked}, 32'd0);
    check("miss_err", {24'd0, err_cnt}, ERR_EN ? 32'd1 : 32'd0);
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    check("miss_relock", {31'd0, locked}, 32'd1);

    $display("phase short line");
    send_frame(1, -1, 1'b0);
    check("short_unlocked", {31'd0, locked}, 32'd0);
    check("short_err", {24'd0, err_cnt}, ERR_EN ? 32'd2 : 32'd0);
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    check("short_relock", {31'd0, locked}, 32'd1);

    $display("phase reset mid-frame");
    for (int l = 0; l < 3; l++) send_line(HT, l < VS, 1'b1);
    for (int i = 0; i < HT; i++) begin
      tick((i < HS) ? 1'b0 : 1'b1, 1'b1);
      if (i == 3) begin
        #2 rst = 1'b1;
        #1 check("reset_mid", {pix_x, pix_y, pix_valid, frame_start, locked, err_cnt}, 32'd0);
      end
      if (i == 5) #2 rst = 1'b0;
    end
    send_line(HT, 1'b0, 1'b1);
    send_line(HT, 1'b0, 1'b1);
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    check("reset_relock", {31'd0, locked}, 32'd1);
    check("reset_err", {24'd0, err_cnt}, 32'd0);

    $display("phase saturation");
    repeat (302) begin
      send_frame(1, -1, 1'b0);
      send_frame(-1, -1, 1'b0);
    end
    send_frame(-1, -1, 1'b0);
    check("sat_err", {24'd0, err_cnt}, ERR_EN ? 32'd255 : 32'd0);
    check("sat_relock", {31'd0, locked}, 32'd1);

    repeat (4) tick(1'b1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Recovers the scan position from a VGA `HS`/`VS` pair, the receive-side counterpart of the `VGA_timing` generator. It runs in the `clk_50m` domain and samples the sync lines with a 2-flop synchronizer. It locks to the 800x600@72 Hz format by measuring line and frame lengths, then outputs active-area pixel coordinates plus lock and error status. Intended uses are loopback self-check of the display path on the board and reuse as a sync monitor in benches.

## Interface
- `H_SYNC`, 120, HS pulse width in clocks
- `H_BP`, 64, horizontal back porch in clocks
- `H_ACT`, 800, active pixels per line
- `H_TOTAL`, 1040, clocks per line
- `V_SYNC`, 6, VS pulse width in lines
- `V_BP`, 23, vertical back porch in lines
- `V_ACT`, 600, active lines
- `V_TOTAL`, 666, lines per frame
- `clk_50m`, in, 1, sole clock; all logic on the rising edge
- `rst`, in, 1, reset; asynchronous and active-high
- `vga_hs`, in, 1, horizontal sync; active-low pulse, idles high
- `vga_vs`, in, 1, vertical sync; active-low pulse, idles high
- `pix_x`, out, 11, active-area column, 0..H_ACT-1
- `pix_y`, out, 10, active-area row, 0..V_ACT-1
- `pix_valid`, out, 1, the current clock is an active pixel and `locked` is 1
- `frame_start`, out, 1, one-cycle pulse on each VS falling edge while locked
- `locked`, out, 1, timing matches parameters
- `err_cnt`, out, 8, saturating count of lock losses

## Operation
- **Synchronizer.** `vga_hs` and `vga_vs` each pass through 2 synchronizer flops plus 1 history flop. A fall is detected when the history flop is 1 and the second sync flop is 0 (`hs_fall`, `vs_fall`).
- **h_cnt (11 bit).**
  - `hs_fall`: load 0.
  - Otherwise: increment, saturating at 2047.
- **Line length.** Line length = `h_cnt + 1` at `hs_fall`.
- **v_cnt (10 bit).**
  - `vs_fall`: load 0.
  - Else `hs_fall`: increment, saturating at 1023.
  - `vs_fall` takes priority when both occur in the same cycle.
- **Frame length.** Frame length = `v_cnt + 1` at `vs_fall`.
- **FSM states.** `SEARCH` (reset state), `HTRACK`, `VTRACK`, `LOCKED`.
  - `SEARCH`: first `hs_fall` goes to `HTRACK`.
  - `HTRACK`: line length != `H_TOTAL` stays in `HTRACK`, with the measurement restarted. A `vs_fall` whose line checks pass goes to `VTRACK`.
  - `VTRACK`:
    - Any line error goes to `SEARCH`.
    - Next `vs_fall` with frame length == `V_TOTAL` goes to `LOCKED`.
    - Next `vs_fall` with frame length != `V_TOTAL` stays in `VTRACK`.
  - `LOCKED`: a line error, or a `vs_fall` with frame length != `V_TOTAL`, goes to `SEARCH` and increments `err_cnt`.
- **Line error** is any one of:
  - line length != `H_TOTAL` at `hs_fall`;
  - `h_cnt` reaching `H_TOTAL` with no `hs_fall` (missing pulse).
- **Coordinates.**
  - Active window: `h_cnt` in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and `v_cnt` in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT).
  - Inside the window: `pix_x` = `h_cnt` − 184 and `pix_y` = `v_cnt` − 29 (with default parameters).
  - Outside the window, or when not `LOCKED`: both are 0 and `pix_valid` is 0.
- **Arithmetic.** Unsigned throughout. Subtractions are evaluated only inside the window, so they never underflow.
- **err_cnt.** Saturates at 255 and never wraps. It clears only on `rst`.

## Timing
- **Reset.** All outputs 0: `pix_x`=0, `pix_y`=0, `pix_valid`=0, `frame_start`=0, `locked`=0, `err_cnt`=0. Also `h_cnt`=0, `v_cnt`=0, FSM=`SEARCH`, synchronizer flops=1.
- **Edge-detect latency.** A sync falling edge between edges k-1 and k gives `hs_fall`/`vs_fall` high during the cycle after edge k+1. Counters load 0 at edge k+2.
- **Output registration.** `pix_x`, `pix_y`, `pix_valid`, `locked`, `frame_start` and `err_cnt` are registered one cycle after the counter and FSM values they derive from.
- **End-to-end latency.** Input fall to `h_cnt`=0 is 2 cycles. Input fall to the outputs reflecting that line is 3 cycles.
- **Lock time.** `locked` rises 1 cycle after the FSM enters `LOCKED`: at the second complete frame after the first `hs_fall`, measured from reset or from the last loss of lock.
- **Loss of lock.** `locked` falls, and `err_cnt` increments, on the same edge, 1 cycle after the FSM leaves `LOCKED`.
- **Same-cycle HS and VS falls** (generator aligns VS to line start): both checks run. `frame_start` pulses if the FSM remains `LOCKED`.
- **Reset mid-frame.** State is discarded immediately. Relock needs 2 full frames.

## Configuration
- `VGA_SYNC_DECODER_ERRCNT_EN` defined: `err_cnt` counter implemented as above.
- Undefined: no counter register is implemented, `err_cnt` is tied to 0, and the FSM is unchanged.

## Test plan
- **Nominal lock.** Drive nominal 1040x666 sync from reset → `locked`=1 three cycles after the 2nd `vs_fall` that follows the first `hs_fall`; `err_cnt`=0.
- **Pixel mapping.** On a locked stream, HS falling at cycle T → `pix_valid`=1 with `pix_x`=0 at cycle T+3+184 on line 29; `pix_x`=799 at T+3+983; `pix_valid`=0 at T+3+984.
- **Missing HS pulse.** Suppress one HS pulse while locked → `locked`=0 and `err_cnt`=1; relock after 2 further good frames.
- **Short line.** One line of 1039 clocks while locked → unlock, `err_cnt` increments; same test with the macro undefined → `err_cnt` stays 0.
- **Reset mid-frame.** Assert `rst` at line 300 → all outputs 0 within the same cycle; relock after 2 frames.
- **Saturation.** Force 300 lock losses → `err_cnt`=255.
